// File: rtl/laser_point_host_if.sv
// Bundle of configuration, engine-stream and result signals between the point host and its environment.
interface laser_point_host_if;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [3:0] cfg_x;
  logic [3:0] cfg_y;
  logic       start;
  logic       busy;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] c1x;
  logic [3:0] c1y;
  logic [3:0] c2x;
  logic [3:0] c2y;
  logic       done;
  logic       res_valid;
  logic [5:0] res_cover;
  logic [3:0] res_c1x;
  logic [3:0] res_c1y;
  logic [3:0] res_c2x;
  logic [3:0] res_c2y;
  logic       res_timeout;

  modport slave (
    input  cfg_we, cfg_addr, cfg_x, cfg_y, start, c1x, c1y, c2x, c2y, done,
    output busy, x, y, res_valid, res_cover, res_c1x, res_c1y, res_c2x, res_c2y, res_timeout
  );

  modport master (
    output cfg_we, cfg_addr, cfg_x, cfg_y, start, c1x, c1y, c2x, c2y, done,
    input  busy, x, y, res_valid, res_cover, res_c1x, res_c1y, res_c2x, res_c2y, res_timeout
  );
endinterface

// File: rtl/laser_point_host.sv
// Host for the two-circle laser engine: streams a 40-point table, captures the
// returned centres and scores how many points fall within radius 4 of either.
module laser_point_host #(
  parameter int unsigned TIMEOUT = 20000
) (
  input logic               clk,
  input logic               rst_n,
  laser_point_host_if.slave bus
);

  localparam int unsigned NPTS      = 40;
  localparam int unsigned RADIUS_SQ = 16;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned CRD_W     = 4;
  localparam int unsigned PT_W      = 2 * CRD_W;
  localparam int unsigned D2_W      = 9;
  localparam int unsigned WCNT_W    = 16;
  localparam int unsigned COV_W     = 6;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SCORE  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

  logic [PT_W-1:0]   r_tab [NPTS];
  logic [2:0]        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [CRD_W-1:0]  r_x, w_x_nxt, r_y, w_y_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_tmo, w_tmo_nxt;
  logic [COV_W-1:0]  r_cover, w_cover_nxt;
  logic [CRD_W-1:0]  r_c1x, r_c1y, r_c2x, r_c2y;
  logic [CRD_W-1:0]  w_c1x_nxt, w_c1y_nxt, w_c2x_nxt, w_c2y_nxt;

  logic [IDX_W-1:0]  w_nidx;
  logic [PT_W-1:0]   w_pt_next, w_pt_cur;
  logic              w_hit;

  // |dx|^2 + |dy|^2; the magnitude of the signed 5-bit difference fits in 4 bits
  function automatic logic [D2_W-1:0] dist_sq(input logic [CRD_W-1:0] px, py, cx, cy);
    logic [CRD_W-1:0]   adx, ady;
    logic [2*CRD_W-1:0] sx, sy;
    adx = (px >= cx) ? px - cx : cx - px;
    ady = (py >= cy) ? py - cy : cy - py;
    sx  = {{CRD_W{1'b0}}, adx} * {{CRD_W{1'b0}}, adx};
    sy  = {{CRD_W{1'b0}}, ady} * {{CRD_W{1'b0}}, ady};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  // Point table: writable only while idle, out-of-range addresses dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NPTS); i++) r_tab[i] <= '0;
    end else if (r_state == S_IDLE && bus.cfg_we && bus.cfg_addr < IDX_W'(NPTS)) begin
      r_tab[bus.cfg_addr] <= {bus.cfg_x, bus.cfg_y};
    end
  end

  // Look-ahead read feeds the registered X/Y so point i appears in STREAM cycle i+1
  assign w_nidx    = (r_state == S_STREAM && r_idx != LAST_IDX) ? r_idx + IDX_W'(1) : '0;
  assign w_pt_next = r_tab[w_nidx];
  assign w_pt_cur  = r_tab[r_idx];

  assign w_hit = (dist_sq(w_pt_cur[PT_W-1:CRD_W], w_pt_cur[CRD_W-1:0], r_c1x, r_c1y) <= D2_W'(RADIUS_SQ)) ||
                 (dist_sq(w_pt_cur[PT_W-1:CRD_W], w_pt_cur[CRD_W-1:0], r_c2x, r_c2y) <= D2_W'(RADIUS_SQ));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wcnt_nxt  = r_wcnt;
    w_x_nxt     = '0;
    w_y_nxt     = '0;
    w_busy_nxt  = 1'b1;
    w_valid_nxt = 1'b0;
    w_tmo_nxt   = r_tmo;
    w_cover_nxt = r_cover;
    w_c1x_nxt   = r_c1x;
    w_c1y_nxt   = r_c1y;
    w_c2x_nxt   = r_c2x;
    w_c2y_nxt   = r_c2y;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (bus.start) begin
          w_state_nxt = S_STREAM;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_cover_nxt = '0;
          w_tmo_nxt   = 1'b0;
          w_x_nxt     = w_pt_next[PT_W-1:CRD_W];
          w_y_nxt     = w_pt_next[CRD_W-1:0];
        end
      end
      S_STREAM: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
          w_x_nxt   = w_pt_next[PT_W-1:CRD_W];
          w_y_nxt   = w_pt_next[CRD_W-1:0];
        end
      end
      S_WAIT: begin
        if (bus.done) begin
          w_state_nxt = S_SCORE;
          w_idx_nxt   = '0;
          w_c1x_nxt   = bus.c1x;
          w_c1y_nxt   = bus.c1y;
          w_c2x_nxt   = bus.c2x;
          w_c2y_nxt   = bus.c2y;
        end else if (r_wcnt == WCNT_W'(TIMEOUT)) begin
          w_state_nxt = S_REPORT;
          w_tmo_nxt   = 1'b1;
          w_valid_nxt = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        end
      end
      S_SCORE: begin
        w_cover_nxt = r_cover + COV_W'(w_hit);
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_REPORT;
          w_valid_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_REPORT: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wcnt  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
      r_cover <= '0;
      r_c1x   <= '0;
      r_c1y   <= '0;
      r_c2x   <= '0;
      r_c2y   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_tmo   <= w_tmo_nxt;
      r_cover <= w_cover_nxt;
      r_c1x   <= w_c1x_nxt;
      r_c1y   <= w_c1y_nxt;
      r_c2x   <= w_c2x_nxt;
      r_c2y   <= w_c2y_nxt;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.res_valid   = r_valid;
  assign bus.res_cover   = r_cover;
  assign bus.res_c1x     = r_c1x;
  assign bus.res_c1y     = r_c1y;
  assign bus.res_c2x     = r_c2x;
  assign bus.res_c2y     = r_c2y;
  assign bus.res_timeout = r_tmo;

endmodule

// File: tb/tb_laser_point_host.sv
// Directed and randomized bench for laser_point_host with a point-distance scoring model.
module tb_laser_point_host;

  localparam int NPTS = 40;
  localparam int TMO  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  laser_point_host_if u_if();

  laser_point_host #(.TIMEOUT(TMO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_px [NPTS];
  int m_py [NPTS];
  int e_c  [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_cover(input int c1x, input int c1y, input int c2x, input int c2y);
    int n;
    n = 0;
    for (int i = 0; i < NPTS; i++) begin
      if ((m_px[i]-c1x)*(m_px[i]-c1x) + (m_py[i]-c1y)*(m_py[i]-c1y) <= 16 ||
          (m_px[i]-c2x)*(m_px[i]-c2x) + (m_py[i]-c2y)*(m_py[i]-c2y) <= 16)
        n++;
    end
    return n;
  endfunction

  task automatic write_table();
    for (int i = 0; i < NPTS; i++) begin
      u_if.cfg_we   = 1'b1;
      u_if.cfg_addr = 6'(i);
      u_if.cfg_x    = 4'(m_px[i]);
      u_if.cfg_y    = 4'(m_py[i]);
      tick();
    end
    u_if.cfg_we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"},       32'(u_if.x), 0);
    chk({tag, "_y"},       32'(u_if.y), 0);
    chk({tag, "_busy"},    32'(u_if.busy), 0);
    chk({tag, "_valid"},   32'(u_if.res_valid), 0);
    chk({tag, "_cover"},   32'(u_if.res_cover), 0);
    chk({tag, "_cent"},    {16'd0, u_if.res_c1x, u_if.res_c1y, u_if.res_c2x, u_if.res_c2y}, 0);
    chk({tag, "_timeout"}, 32'(u_if.res_timeout), 0);
  endtask

  // One complete run starting now; engine answers after lat WAIT cycles unless no_done
  task automatic run(input string tag, input int lat, input bit no_done,
                     input int c1x, input int c1y, input int c2x, input int c2y, input bit noise);
    int  cyc;
    int  exp_cyc;
    bit  seen;
    seen = 1'b0;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    for (cyc = 1; cyc < 600; cyc++) begin
      if (cyc == 1) begin
        chk({tag, "_busy1"},  32'(u_if.busy), 1);
        chk({tag, "_clrcov"}, 32'(u_if.res_cover), 0);
        chk({tag, "_clrtmo"}, 32'(u_if.res_timeout), 0);
      end
      if (cyc <= NPTS) begin
        chk($sformatf("%s_x%0d", tag, cyc-1), 32'(u_if.x), 32'(m_px[cyc-1]));
        chk($sformatf("%s_y%0d", tag, cyc-1), 32'(u_if.y), 32'(m_py[cyc-1]));
      end else if (cyc == NPTS + 1) begin
        chk({tag, "_xy_after"}, {24'd0, u_if.x, u_if.y}, 0);
      end
      if (u_if.res_valid) begin
        seen = 1'b1;
        break;
      end
      if (noise && cyc == 20) begin
        u_if.done = 1'b1;
        u_if.c1x = 4'd1; u_if.c1y = 4'd2; u_if.c2x = 4'd3; u_if.c2y = 4'd4;
      end
      if (noise && cyc == NPTS + 5) begin
        u_if.start    = 1'b1;
        u_if.cfg_we   = 1'b1;
        u_if.cfg_addr = 6'd3;
        u_if.cfg_x    = 4'd9;
        u_if.cfg_y    = 4'd9;
      end
      if (!no_done && cyc == NPTS + 1 + lat) begin
        u_if.done = 1'b1;
        u_if.c1x = 4'(c1x); u_if.c1y = 4'(c1y); u_if.c2x = 4'(c2x); u_if.c2y = 4'(c2y);
      end
      tick();
      u_if.done   = 1'b0;
      u_if.start  = 1'b0;
      u_if.cfg_we = 1'b0;
    end
    chk({tag, "_valid_seen"}, 32'(seen), 1);
    exp_cyc = no_done ? NPTS + 1 + TMO + 1 : NPTS + 1 + lat + NPTS + 1;
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    if (!no_done) begin
      e_c[0] = c1x; e_c[1] = c1y; e_c[2] = c2x; e_c[3] = c2y;
    end
    chk({tag, "_timeout"}, 32'(u_if.res_timeout), 32'(no_done));
    chk({tag, "_cover"}, 32'(u_if.res_cover), no_done ? 0 : 32'(model_cover(c1x, c1y, c2x, c2y)));
    chk({tag, "_c1x"}, 32'(u_if.res_c1x), 32'(e_c[0]));
    chk({tag, "_c1y"}, 32'(u_if.res_c1y), 32'(e_c[1]));
    chk({tag, "_c2x"}, 32'(u_if.res_c2x), 32'(e_c[2]));
    chk({tag, "_c2y"}, 32'(u_if.res_c2y), 32'(e_c[3]));
    chk({tag, "_busy_rep"}, 32'(u_if.busy), 1);
    tick();
    chk({tag, "_valid_pulse"}, 32'(u_if.res_valid), 0);
    chk({tag, "_busy_idle"}, 32'(u_if.busy), 0);
    chk({tag, "_tmo_hold"}, 32'(u_if.res_timeout), 32'(no_done));
  endtask

  initial begin
    u_if.cfg_we = 1'b0; u_if.cfg_addr = '0; u_if.cfg_x = '0; u_if.cfg_y = '0;
    u_if.start  = 1'b0; u_if.done = 1'b0;
    u_if.c1x = '0; u_if.c1y = '0; u_if.c2x = '0; u_if.c2y = '0;
    for (int i = 0; i < 4; i++) e_c[i] = 0;

    // Reset state and a quiet idle period
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_quiet", {28'd0, u_if.x == 4'd0, u_if.y == 4'd0, u_if.busy, u_if.res_valid}, 32'hC);
    end

    // Stream ordering with a ramp table
    for (int i = 0; i < NPTS; i++) begin m_px[i] = i % 16; m_py[i] = i / 16; end
    write_table();
    run("stream", 5, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
        int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

    // Two disjoint clusters fully covered
    for (int i = 0; i < NPTS; i++) begin
      m_px[i] = (i < 20) ? 3 : 12;
      m_py[i] = (i < 20) ? 3 : 12;
    end
    write_table();
    run("noovl", 7, 1'b0, 3, 3, 12, 12, 1'b0);
    chk("noovl_cover40", 32'(u_if.res_cover), 40);

    // Radius boundary with coincident circles
    for (int i = 0; i < NPTS; i++) begin m_px[i] = 15; m_py[i] = 15; end
    m_px[0] = 7; m_py[0] = 3;
    m_px[1] = 7; m_py[1] = 4;
    m_px[2] = 4; m_py[2] = 4;
    m_px[3] = 0; m_py[3] = 0;
    write_table();
    run("bound", 3, 1'b0, 4, 4, 4, 4, 1'b0);
    chk("bound_cover3", 32'(u_if.res_cover), 3);

    // No DONE: abort after the wait budget, centres retained
    run("tmo", 0, 1'b1, 0, 0, 0, 0, 1'b0);

    // Stray DONE in STREAM, start/cfg_we in WAIT; then confirm table intact back-to-back
    run("noise", 10, 1'b0, 5, 6, 9, 10, 1'b1);
    run("after_noise", 2, 1'b0, 7, 3, 1, 1, 1'b0);

    // Randomized tables, centres and engine latency
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NPTS; i++) begin
        m_px[i] = int'($urandom_range(0, 15));
        m_py[i] = int'($urandom_range(0, 15));
      end
      write_table();
      run($sformatf("rand%0d", r), int'($urandom_range(0, 30)), 1'b0,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
    end

    // Reset in STREAM cycle 20 aborts the run and clears the table
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("midrst_quiet", {29'd0, u_if.busy, u_if.res_valid, u_if.x != 4'd0}, 0);
    end
    for (int i = 0; i < NPTS; i++) begin m_px[i] = 0; m_py[i] = 0; end
    for (int i = 0; i < 4; i++) e_c[i] = 0;
    run("postrst", 4, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
        int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
